// File: rtl/asrv32_memoryaccess.sv
// asrv32_memoryaccess: RV32I memory-access stage driving a pipelined Wishbone data port.
// Latency: 1 cycle for non-memory ops; loads/stores deliver o_ce one cycle after the bus ack.
// Backpressure: o_stall holds upstream for the whole bus access and mirrors i_stall, which freezes the stage.
// Optional: define ASRV32_MISALIGNED_TRAP_EN to trap misaligned half/word accesses instead of issuing them.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module asrv32_memoryaccess (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [2:0]               i_funct3,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [31:0]              i_y,
    input  logic [31:0]              i_rs2_data,
    input  logic                     i_wr_rd_en,
    input  logic [4:0]               i_rd_addr,
    input  logic [31:0]              i_rd_data,
    input  logic [31:0]              i_pc,
    output logic                     o_wr_rd_en,
    output logic [4:0]               o_rd_addr,
    output logic [31:0]              o_rd_data,
    output logic [31:0]              o_pc,
    output logic [2:0]               o_funct3,
    output logic [`OPCODE_WIDTH-1:0] o_opcode,
    output logic [31:0]              o_load_data,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [31:0]              o_wb_addr,
    output logic [31:0]              o_wb_data,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic [31:0]              i_wb_data,
    input  logic                     i_ce,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_ce,
    output logic                     o_stall,
    output logic                     o_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Pipeline registers handed to writeback
    logic                     r_wr_rd_en;
    logic [4:0]               r_rd_addr;
    logic [31:0]              r_rd_data;
    logic [31:0]              r_pc;
    logic [2:0]               r_funct3;
    logic [`OPCODE_WIDTH-1:0] r_opcode;
    logic [31:0]              r_load_data;
    logic                     r_ce;

    // Bus request registers
    logic [31:0]              r_wb_addr;
    logic [31:0]              r_wb_data;
    logic [3:0]               r_wb_sel;
    logic                     r_wb_we;
    logic [1:0]               r_off;

    // r_pend: ack taken while downstream stalled, o_ce still owed.
    // r_flushed: a flush hit the in-flight access, so its o_ce is dropped.
    logic                     r_pend;
    logic                     r_flushed;

    logic                     w_is_mem;
    logic                     w_misalign;
    logic                     w_accept;
    logic                     w_start_bus;
    logic                     w_ack;
    logic                     w_cyc;
    logic                     w_stb;
    logic [3:0]               w_sel;
    logic [31:0]              w_wdata;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [31:0]              w_load_ext;

    assign w_is_mem    = i_opcode[`LOAD] | i_opcode[`STORE];
    // A pending o_ce blocks new work so the owed result is never overwritten.
    assign w_accept    = (r_state == IDLE) & i_ce & ~i_stall & ~i_flush & ~r_pend;
    assign w_start_bus = w_accept & w_is_mem & ~w_misalign;
    // Acks are only meaningful while a cycle is open; stray acks in IDLE are dropped.
    assign w_ack       = (r_state != IDLE) & i_wb_ack;

`ifdef ASRV32_MISALIGNED_TRAP_EN
    logic r_misaligned;

    assign w_misalign = w_is_mem &
                        (((i_funct3[1:0] == 2'b01) & i_y[0]) |
                         ((i_funct3[1:0] == 2'b10) & (i_y[1:0] != 2'b00)));

    // Remember whether the accepted instruction trapped; flag rides on o_ce.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_misaligned <= 1'b0;
        else if (w_accept)
            r_misaligned <= w_misalign;
    end

    assign o_misaligned = r_misaligned & r_ce;
`else
    assign w_misalign   = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Byte lanes and replicated store data from the access width and low address bits.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = i_rs2_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_sel   = 4'b0001 << i_y[1:0];
                w_wdata = {4{i_rs2_data[7:0]}};
            end
            2'b01: begin
                w_sel   = 4'b0011 << {i_y[1], 1'b0};
                w_wdata = {2{i_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        w_byte     = i_wb_data[{r_off, 3'b000} +: 8];
        w_half     = r_off[1] ? i_wb_data[31:16] : i_wb_data[15:0];
        w_load_ext = i_wb_data;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = i_wb_data;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and bus strobes: stb lives only in REQ, cyc spans REQ and WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_bus)
                    w_state_nxt = REQ;
            end
            REQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                if (i_wb_ack)
                    w_state_nxt = IDLE;
                else if (!i_wb_stall)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                w_cyc = 1'b1;
                if (i_wb_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the bus request once at the accept edge; it stays stable while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_addr <= 32'd0;
            r_wb_data <= 32'd0;
            r_wb_sel  <= 4'd0;
            r_wb_we   <= 1'b0;
            r_off     <= 2'd0;
        end else if (w_start_bus) begin
            r_wb_addr <= {i_y[31:2], 2'b00};
            r_wb_data <= w_wdata;
            r_wb_sel  <= w_sel;
            r_wb_we   <= i_opcode[`STORE];
            r_off     <= i_y[1:0];
        end
    end

    // Capture pass-through fields on accept; a trapped access must not write rd.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_rd_en <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_rd_data  <= 32'd0;
            r_pc       <= 32'd0;
            r_funct3   <= 3'd0;
            r_opcode   <= '0;
        end else if (w_accept) begin
            r_wr_rd_en <= i_wr_rd_en & ~w_misalign;
            r_rd_addr  <= i_rd_addr;
            r_rd_data  <= i_rd_data;
            r_pc       <= i_pc;
            r_funct3   <= i_funct3;
            r_opcode   <= i_opcode;
        end
    end

    // Load result is latched on the ack even if downstream is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_load_data <= 32'd0;
        else if (w_ack && r_opcode[`LOAD])
            r_load_data <= w_load_ext;
    end

    // Track flushes that land on an in-flight access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_flushed <= 1'b0;
        else if (w_ack)
            r_flushed <= 1'b0;
        else if ((r_state != IDLE) && i_flush)
            r_flushed <= 1'b1;
    end

    // o_ce generation: one-cycle pulse per retired instruction, held under stall, killed by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ce   <= 1'b0;
            r_pend <= 1'b0;
        end else if (r_state == IDLE) begin
            if (i_flush) begin
                r_ce   <= 1'b0;
                r_pend <= 1'b0;
            end else if (i_stall) begin
                r_ce   <= r_ce;
            end else if (r_pend) begin
                r_ce   <= 1'b1;
                r_pend <= 1'b0;
            end else begin
                r_ce   <= w_accept & ~w_start_bus;
            end
        end else begin
            r_ce <= 1'b0;
            if (i_wb_ack && !(r_flushed || i_flush)) begin
                if (i_stall)
                    r_pend <= 1'b1;
                else
                    r_ce   <= 1'b1;
            end
        end
    end

    assign o_wr_rd_en  = r_wr_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_rd_data   = r_rd_data;
    assign o_pc        = r_pc;
    assign o_funct3    = r_funct3;
    assign o_opcode    = r_opcode;
    assign o_load_data = r_load_data;
    assign o_ce        = r_ce;
    assign o_wb_cyc    = w_cyc;
    assign o_wb_stb    = w_stb;
    assign o_wb_we     = r_wb_we & w_cyc;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_data   = r_wb_data;
    assign o_wb_sel    = r_wb_sel;
    assign o_stall     = i_rst_n & ((r_state != IDLE) | r_pend | i_stall);

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// Testbench for asrv32_memoryaccess: directed scenarios plus randomized loads/stores.
// A behavioural bus responder drives stall/ack; expectations come from an arithmetic model.
// Works with or without ASRV32_MISALIGNED_TRAP_EN defined.
module tb_asrv32_memoryaccess;

    localparam int OPW = 11;
    localparam logic [OPW-1:0] OP_ADD   = 11'b000_0000_0001;
    localparam logic [OPW-1:0] OP_LOAD  = 11'b000_0000_0100;
    localparam logic [OPW-1:0] OP_STORE = 11'b000_0000_1000;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [2:0]     i_funct3;
    logic [OPW-1:0] i_opcode;
    logic [31:0]    i_y, i_rs2_data, i_rd_data, i_pc, i_wb_data;
    logic           i_wr_rd_en, i_wb_ack, i_wb_stall, i_ce, i_stall, i_flush;
    logic [4:0]     i_rd_addr;
    logic           o_wr_rd_en, o_wb_cyc, o_wb_stb, o_wb_we, o_ce, o_stall, o_misaligned;
    logic [4:0]     o_rd_addr;
    logic [31:0]    o_rd_data, o_pc, o_load_data, o_wb_addr, o_wb_data;
    logic [2:0]     o_funct3;
    logic [OPW-1:0] o_opcode;
    logic [3:0]     o_wb_sel;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    asrv32_memoryaccess dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_funct3(i_funct3), .i_opcode(i_opcode),
        .i_y(i_y), .i_rs2_data(i_rs2_data), .i_wr_rd_en(i_wr_rd_en), .i_rd_addr(i_rd_addr),
        .i_rd_data(i_rd_data), .i_pc(i_pc), .o_wr_rd_en(o_wr_rd_en), .o_rd_addr(o_rd_addr),
        .o_rd_data(o_rd_data), .o_pc(o_pc), .o_funct3(o_funct3), .o_opcode(o_opcode),
        .o_load_data(o_load_data), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack),
        .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_ce(i_ce), .i_stall(i_stall),
        .i_flush(i_flush), .o_ce(o_ce), .o_stall(o_stall), .o_misaligned(o_misaligned)
    );

    typedef struct packed {
        logic        cyc0;
        logic        stb0;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] data0;
        logic [3:0]  sel0;
        int          stb_cnt;
        int          stall_cnt;
        int          win_ce;
        int          addr_moves;
        int          ce_cnt;
        int          ce_idx;
        logic        cyc_after;
        logic        wr_en;
        logic        mis;
        logic [31:0] ld;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset of the naturally aligned lane group inside the word.
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] y);
        int sz = acc_size(f3);
        if (sz == 4) return 0;
        return (int'(y % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] f3, input logic [31:0] y);
        int v = ((1 << acc_size(f3)) - 1) << lane_off(f3, y);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz = acc_size(f3);
        if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] y,
                                             input logic [31:0] word);
        int    sz   = acc_size(f3);
        longint w   = longint'(word);
        longint v   = (w >> (8 * lane_off(f3, y))) & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- driver: one memory instruction with bus responder ----------------
    // nstall: bus stall cycles in REQ; nwait: WAIT cycles before the ack cycle;
    // dstall: i_stall held from the ack cycle for this many extra cycles.
    task automatic run_mem(input logic [OPW-1:0] op, input logic [2:0] f3,
                           input logic [31:0] y, input logic [31:0] rs2, input logic [31:0] rdata,
                           input int nstall, input int nwait, input int dstall,
                           input bit flush_wait, output obs_t ob);
        int total;
        ob = '0;
        ob.ce_idx = -1;
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = op; i_funct3 = f3; i_y = y; i_rs2_data = rs2;
        i_wr_rd_en = (op == OP_LOAD); i_rd_addr = 5'($urandom); i_rd_data = $urandom;
        i_pc = $urandom; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        @(negedge i_clk);
        i_ce = 1'b0; i_opcode = OP_ADD; i_y = $urandom; i_rs2_data = $urandom;
        ob.cyc0 = o_wb_cyc; ob.stb0 = o_wb_stb; ob.we0 = o_wb_we;
        ob.addr0 = o_wb_addr; ob.data0 = o_wb_data; ob.sel0 = o_wb_sel;
        total = nstall + nwait + 2;
        for (int k = 0; k < total; k++) begin
            i_wb_stall = (k < nstall);
            i_wb_ack   = (k == total - 1);
            i_wb_data  = (k == total - 1) ? rdata : $urandom;
            i_stall    = (k == total - 1) && (dstall > 0);
            i_flush    = flush_wait && (k == nstall + 1);
            #1;
            ob.stb_cnt   += int'(o_wb_stb);
            ob.stall_cnt += int'(o_stall);
            ob.win_ce    += int'(o_ce);
            if (o_wb_addr !== ob.addr0) ob.addr_moves++;
            @(negedge i_clk);
        end
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_flush = 1'b0;
        for (int p = 0; p < 8; p++) begin
            i_stall   = (p < dstall);
            i_wb_data = $urandom;
            #1;
            if (p == 0) ob.cyc_after = o_wb_cyc;
            if (o_ce === 1'b1) begin
                if (ob.ce_idx < 0) begin
                    ob.ce_idx = p; ob.ld = o_load_data; ob.wr_en = o_wr_rd_en; ob.mis = o_misaligned;
                end
                ob.ce_cnt++;
            end
            @(negedge i_clk);
        end
        i_stall = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_ce = 1'b1; i_opcode = OP_LOAD; i_y = 32'h100; i_funct3 = 3'b010;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if ({o_ce, o_stall, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd_en, o_misaligned} !== 7'd0)
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {o_ce, o_stall, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd_en, o_misaligned});
        else n_pass++;
        n_checks++;
        if ({o_rd_addr, o_rd_data, o_pc, o_funct3, o_opcode, o_load_data, o_wb_addr, o_wb_data, o_wb_sel} !== '0)
            $display("FAIL reset_data: outputs not zero (addr %h data %h ld %h)", o_wb_addr, o_wb_data, o_load_data);
        else n_pass++;
        i_ce = 1'b0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_lb_example();
        obs_t ob;
        run_mem(OP_LOAD, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 2, 0, 1'b0, ob);
        n_checks++;
        if (ob.ld !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", ob.ld); else n_pass++;
        n_checks++;
        if (ob.ce_cnt != 1 || ob.win_ce != 0 || ob.ce_idx != 0)
            $display("FAIL lb_ce_pulse: got cnt %0d early %0d idx %0d want 1 0 0", ob.ce_cnt, ob.win_ce, ob.ce_idx);
        else n_pass++;
        n_checks++;
        if (ob.stall_cnt != 4) $display("FAIL lb_stall_len: got %0d want 4", ob.stall_cnt); else n_pass++;
        n_checks++;
        if ({ob.cyc0, ob.stb0, ob.we0, ob.addr0, ob.sel0} !== {3'b110, 32'h1000, 4'b1000})
            $display("FAIL lb_req: got cyc%b stb%b we%b addr %h sel %b want 1 1 0 00001000 1000",
                     ob.cyc0, ob.stb0, ob.we0, ob.addr0, ob.sel0);
        else n_pass++;
        n_checks++;
        if (ob.cyc_after !== 1'b0) $display("FAIL lb_cyc_drop: got %b want 0", ob.cyc_after); else n_pass++;
    endtask

    task automatic test_sh_example();
        obs_t ob;
        run_mem(OP_STORE, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 0, 0, 1'b0, ob);
        n_checks++;
        if ({ob.sel0, ob.data0, ob.addr0, ob.we0} !== {4'b1100, 32'hABCD_ABCD, 32'h2000, 1'b1})
            $display("FAIL sh_req: got sel %b data %h addr %h we %b want 1100 abcdabcd 00002000 1",
                     ob.sel0, ob.data0, ob.addr0, ob.we0);
        else n_pass++;
        n_checks++;
        if (ob.ce_cnt != 1) $display("FAIL sh_ce: got %0d want 1", ob.ce_cnt); else n_pass++;
    endtask

    task automatic test_lw_stall();
        obs_t ob;
        run_mem(OP_LOAD, 3'b010, 32'h0000_7A48, 32'h0, 32'h1357_9BDF, 3, 1, 0, 1'b0, ob);
        // stb covers the three stalled cycles plus the accepting one
        n_checks++;
        if (ob.stb_cnt != 4) $display("FAIL lw_stb_len: got %0d want 4", ob.stb_cnt); else n_pass++;
        n_checks++;
        if (ob.addr_moves != 0 || ob.addr0 !== 32'h0000_7A48)
            $display("FAIL lw_addr_stable: got moves %0d addr %h want 0 00007a48", ob.addr_moves, ob.addr0);
        else n_pass++;
        n_checks++;
        if (ob.win_ce != 0 || ob.ce_cnt != 1 || ob.ld !== 32'h1357_9BDF)
            $display("FAIL lw_result: got early %0d cnt %0d ld %h want 0 1 13579bdf", ob.win_ce, ob.ce_cnt, ob.ld);
        else n_pass++;
    endtask

    task automatic test_flush_wait();
        obs_t ob;
        run_mem(OP_LOAD, 3'b101, 32'h4002, 32'h0, 32'h9234_5678, 0, 2, 0, 1'b1, ob);
        n_checks++;
        if (ob.ce_cnt != 0 || ob.win_ce != 0) $display("FAIL flush_ce: got %0d want 0", ob.ce_cnt + ob.win_ce);
        else n_pass++;
        n_checks++;
        if (ob.stall_cnt != 4 || ob.cyc_after !== 1'b0)
            $display("FAIL flush_complete: got stall %0d cyc_after %b want 4 0", ob.stall_cnt, ob.cyc_after);
        else n_pass++;
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = OP_ADD; i_rd_data = 32'h0000_1234; i_rd_addr = 5'd7; i_wr_rd_en = 1'b1;
        @(negedge i_clk);
        i_ce = 1'b0;
        n_checks++;
        if ({o_ce, o_rd_data, o_rd_addr} !== {1'b1, 32'h0000_1234, 5'd7})
            $display("FAIL flush_next_add: got ce %b rd %h addr %0d want 1 00001234 7", o_ce, o_rd_data, o_rd_addr);
        else n_pass++;
    endtask

    task automatic test_flush_accept();
        int cyc_seen = 0;
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_y = 32'h8000; i_flush = 1'b1;
        @(negedge i_clk);
        i_ce = 1'b0; i_flush = 1'b0;
        cyc_seen += int'(o_wb_cyc);
        n_checks++;
        if (o_ce !== 1'b0) $display("FAIL flush_accept_ce: got %b want 0", o_ce); else n_pass++;
        repeat (2) begin
            @(negedge i_clk);
            cyc_seen += int'(o_wb_cyc);
        end
        n_checks++;
        if (cyc_seen != 0) $display("FAIL flush_accept_cyc: got %0d cyc cycles want 0", cyc_seen); else n_pass++;
    endtask

    task automatic test_nonmem_stall();
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = OP_ADD; i_rd_data = 32'hCAFE_0001; i_wr_rd_en = 1'b1; i_pc = 32'h40;
        @(negedge i_clk);
        n_checks++;
        if ({o_ce, o_rd_data, o_pc} !== {1'b1, 32'hCAFE_0001, 32'h40})
            $display("FAIL add_latency: got ce %b rd %h pc %h want 1 cafe0001 00000040", o_ce, o_rd_data, o_pc);
        else n_pass++;
        i_stall = 1'b1; i_opcode = OP_LOAD; i_rd_data = 32'hDEAD_0002; i_pc = 32'h44;
        #1;
        n_checks++;
        if (o_stall !== 1'b1) $display("FAIL stall_mirror: got %b want 1", o_stall); else n_pass++;
        @(negedge i_clk);
        n_checks++;
        if ({o_rd_data, o_pc, o_wb_cyc} !== {32'hCAFE_0001, 32'h40, 1'b0})
            $display("FAIL stall_hold: got rd %h pc %h cyc %b want cafe0001 00000040 0", o_rd_data, o_pc, o_wb_cyc);
        else n_pass++;
        i_stall = 1'b0; i_ce = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_ce !== 1'b0) $display("FAIL ce_idle: got %b want 0", o_ce); else n_pass++;
    endtask

    task automatic test_ack_stall();
        obs_t ob;
        run_mem(OP_LOAD, 3'b100, 32'h5002, 32'h0, 32'h00C3_0000, 0, 1, 3, 1'b0, ob);
        n_checks++;
        if (ob.ce_idx != 4 || ob.ce_cnt != 1)
            $display("FAIL ack_stall_ce: got idx %0d cnt %0d want 4 1", ob.ce_idx, ob.ce_cnt);
        else n_pass++;
        n_checks++;
        if (ob.ld !== 32'h0000_00C3) $display("FAIL ack_stall_data: got %h want 000000c3", ob.ld); else n_pass++;
    endtask

    task automatic test_misaligned();
`ifdef ASRV32_MISALIGNED_TRAP_EN
        int cyc_seen = 0;
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_y = 32'h3001; i_wr_rd_en = 1'b1;
        @(negedge i_clk);
        i_ce = 1'b0;
        cyc_seen += int'(o_wb_cyc);
        n_checks++;
        if ({o_ce, o_misaligned, o_wr_rd_en} !== 3'b110)
            $display("FAIL trap_flags: got ce %b mis %b wr %b want 1 1 0", o_ce, o_misaligned, o_wr_rd_en);
        else n_pass++;
        repeat (3) begin
            @(negedge i_clk);
            cyc_seen += int'(o_wb_cyc);
        end
        n_checks++;
        if (cyc_seen != 0) $display("FAIL trap_no_bus: got %0d cyc cycles want 0", cyc_seen); else n_pass++;
`else
        obs_t ob;
        run_mem(OP_LOAD, 3'b010, 32'h3001, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 1'b0, ob);
        n_checks++;
        if ({ob.cyc0, ob.addr0, ob.sel0} !== {1'b1, 32'h3000, 4'b1111})
            $display("FAIL misalign_bus: got cyc %b addr %h sel %b want 1 00003000 1111", ob.cyc0, ob.addr0, ob.sel0);
        else n_pass++;
        n_checks++;
        if ({ob.mis, ob.ld} !== {1'b0, 32'h0BAD_F00D})
            $display("FAIL misalign_result: got mis %b ld %h want 0 0badf00d", ob.mis, ob.ld);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        obs_t        ob;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int it = 0; it < 40; it++) begin
            bit          is_ld = $urandom_range(0, 1) == 1;
            logic [2:0]  f3    = is_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            logic [31:0] y     = $urandom;
            logic [31:0] rs2   = $urandom;
            logic [31:0] rd    = $urandom;
            int          ns    = $urandom_range(0, 2);
            int          nw    = $urandom_range(0, 3);
`ifdef ASRV32_MISALIGNED_TRAP_EN
            y = y - (y % acc_size(f3));
`endif
            run_mem(is_ld ? OP_LOAD : OP_STORE, f3, y, rs2, rd, ns, nw, 0, 1'b0, ob);
            n_checks++;
            if ({ob.addr0, ob.sel0, ob.we0} !== {y & 32'hFFFF_FFFC, ref_sel(f3, y), !is_ld})
                $display("FAIL rnd_req[%0d]: got addr %h sel %b we %b want %h %b %b", it, ob.addr0, ob.sel0,
                         ob.we0, y & 32'hFFFF_FFFC, ref_sel(f3, y), !is_ld);
            else n_pass++;
            n_checks++;
            if (ob.ce_cnt != 1 || ob.win_ce != 0 || ob.stall_cnt != ns + nw + 2 || ob.stb_cnt != ns + 1)
                $display("FAIL rnd_timing[%0d]: got ce %0d early %0d stall %0d stb %0d want 1 0 %0d %0d", it,
                         ob.ce_cnt, ob.win_ce, ob.stall_cnt, ob.stb_cnt, ns + nw + 2, ns + 1);
            else n_pass++;
            n_checks++;
            if (is_ld) begin
                if ({ob.ld, ob.wr_en} !== {ref_load(f3, y, rd), 1'b1})
                    $display("FAIL rnd_load[%0d]: f3 %b y %h got %h wr %b want %h 1", it, f3, y, ob.ld,
                             ob.wr_en, ref_load(f3, y, rd));
                else n_pass++;
            end else begin
                if (ob.data0 !== ref_wdata(f3, rs2))
                    $display("FAIL rnd_store[%0d]: f3 %b got %h want %h", it, f3, ob.data0, ref_wdata(f3, rs2));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [6:0] ctrl_acc = '0;
        logic       data_nz  = 1'b0;
        @(negedge i_clk);
        i_ce = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_y = 32'h6000; i_wr_rd_en = 1'b1;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0;
        @(negedge i_clk);
        i_ce = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) $display("FAIL midrst_wait: got cyc %b stb %b want 1 0", o_wb_cyc, o_wb_stb);
        else n_pass++;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b00) $display("FAIL midrst_drop: got cyc %b stb %b want 0 0", o_wb_cyc, o_wb_stb);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_wb_ack = 1'b1; i_wb_data = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ctrl_acc |= {o_ce, o_stall, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd_en, o_misaligned};
            if ({o_rd_data, o_pc, o_load_data, o_wb_addr, o_wb_data, o_wb_sel} !== '0) data_nz = 1'b1;
            @(negedge i_clk);
        end
        n_checks++;
        if (ctrl_acc !== 7'd0 || data_nz !== 1'b0)
            $display("FAIL midrst_stray_ack: got ctrl %b data_nonzero %b want 0 0", ctrl_acc, data_nz);
        else n_pass++;
        i_ce = 1'b1; i_opcode = OP_ADD; i_rd_data = 32'h0000_0ADD;
        @(negedge i_clk);
        i_ce = 1'b0;
        n_checks++;
        if ({o_ce, o_rd_data} !== {1'b1, 32'h0000_0ADD})
            $display("FAIL midrst_idle: got ce %b rd %h want 1 00000add", o_ce, o_rd_data);
        else n_pass++;
    endtask

    initial begin
        i_rst_n = 1'b0; i_funct3 = '0; i_opcode = '0; i_y = '0; i_rs2_data = '0; i_rd_data = '0;
        i_pc = '0; i_wb_data = '0; i_wr_rd_en = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0;
        i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_rd_addr = '0;
        test_reset();
        test_lb_example();
        test_sh_example();
        test_lw_stall();
        test_flush_wait();
        test_flush_accept();
        test_nonmem_stall();
        test_ack_stall();
        test_misaligned();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/asrv32_memoryaccess.md
ASRV32_MEMORYACCESS -- requirements
Module: asrv32_memoryaccess

Interface
REQ-001 Parameters: none; the widths are fixed by the RV32I datapath.
REQ-002 i_clk  in  1  clock, rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_funct3  in  3  load/store width and signedness code from the ALU stage.
REQ-005 i_opcode  in  `OPCODE_WIDTH  one-hot opcode from the ALU stage.
REQ-006 i_y  in  32  ALU result, used as the effective address for loads and stores.
REQ-007 i_rs2_data  in  32  store data.
REQ-008 i_wr_rd_en / i_rd_addr / i_rd_data / i_pc  in  1/5/32/32  fields passed through from the ALU stage.
REQ-009 o_wr_rd_en / o_rd_addr / o_rd_data / o_pc / o_funct3 / o_opcode  out  1/5/32/32/3/`OPCODE_WIDTH  registered copies of the input fields, sent to writeback.
REQ-010 o_load_data  out  32  load result, already extended, sent to writeback.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  data-bus cycle, strobe and write-enable signals.
REQ-012 o_wb_addr / o_wb_data / o_wb_sel  out  32/32/4  data-bus word address, write data and byte lanes.
REQ-013 i_wb_ack / i_wb_stall / i_wb_data  in  1/1/32  data-bus acknowledge, stall and read data.
REQ-014 Pipeline ports: i_ce in 1 (stage enable); i_stall in 1 (stall from downstream); i_flush in 1 (flush from writeback); o_ce out 1 (writeback enable); o_stall out 1 (stall request upstream).
REQ-015 o_misaligned  out  1  misaligned-access flag that accompanies o_ce.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-017 IDLE to REQ SHALL occur when i_ce=1, i_stall=0, i_flush=0 and the opcode is LOAD or STORE; on that edge cyc=1, stb=1, we=STORE, and the address, sel and data are registered.
REQ-018 o_wb_addr SHALL be {i_y[31:2],2'b00}.
REQ-019 o_wb_sel SHALL be: byte 4'b0001<<y[1:0]; half 4'b0011<<{y[1],1'b0}; word 4'b1111.
REQ-020 o_wb_data SHALL be: byte rs2[7:0] replicated x4; half rs2[15:0] replicated x2; word rs2.
REQ-021 In REQ, stb SHALL hold while i_wb_stall=1; the first cycle with i_wb_stall=0 SHALL drop stb and go to WAIT.
REQ-022 If i_wb_ack is seen in REQ or in WAIT, the stage SHALL return to IDLE with cyc=0 and o_ce=1 for exactly one cycle.
REQ-023 On a load ack, o_load_data SHALL be formed as follows, using the registered offset:
- LB/LH: sign-extended byte/half.
- LBU/LHU: zero-extended byte/half.
- LW: full word.
REQ-024 o_stall SHALL be 1 from the accept edge through the ack cycle, and also whenever i_stall=1.
REQ-025 A non-memory instruction accepted in IDLE SHALL register its fields and assert o_ce on the next cycle (1-cycle latency).
REQ-026 Pipeline registers SHALL hold while i_stall=1; o_ce SHALL be 0 when i_ce=0.
REQ-027 If i_flush=1 while a bus access is in flight, the bus access SHALL complete, but its o_ce SHALL be suppressed; if i_flush=1 in IDLE, o_ce=0 on the next cycle.
REQ-028 If i_flush and an accept condition occur in the same cycle, i_flush SHALL win and no bus request is issued.
REQ-029 If i_wb_ack arrives while i_stall=1, the load data SHALL be latched and o_ce SHALL be delayed until i_stall=0.

Reset
REQ-030 While i_rst_n=0, the stage SHALL be in IDLE with all of the following at 0: o_ce, o_stall, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd_en, o_misaligned, and every data/address output.
REQ-031 A reset asserted mid-transaction SHALL drop cyc/stb immediately; a late ack after reset release SHALL be ignored while in IDLE.

Configuration
REQ-032 With ASRV32_MISALIGNED_TRAP_EN defined, a misaligned half (y[0]=1) or word (y[1:0]!=0) SHALL issue no bus cycle; the stage SHALL assert o_ce and o_misaligned together one cycle after acceptance, with o_wr_rd_en=0.
REQ-033 Without ASRV32_MISALIGNED_TRAP_EN, the access SHALL be issued with its low address bits ignored (word-aligned lanes per REQ-019), and o_misaligned SHALL be tied to 0.

Verification
REQ-034 LB, y=0x1003, memory word 0x80FF_1234, ack after 2 wait cycles -> o_load_data=0xFFFF_FF80, o_ce pulses once, o_stall high for 4 cycles.
REQ-035 SH, y=0x2002, rs2=0x0000_ABCD -> o_wb_sel=4'b1100, o_wb_data=0xABCD_ABCD, o_wb_addr=0x2000, we=1.
REQ-036 LW with i_wb_stall=1 for 3 cycles -> stb held 3 cycles then dropped, address stable throughout, no o_ce before ack.
REQ-037 i_flush asserted during WAIT of an LHU -> transaction completes, o_ce stays 0, next ADD passes through with 1-cycle latency.
REQ-038 Macro defined, LW at y=0x3001 -> cyc never asserted, o_misaligned=1 with o_ce; macro undefined -> bus read at 0x3000, sel=4'b1111.
REQ-039 Reset pulsed while in WAIT, then a stray ack -> outputs stay 0, FSM remains in IDLE.
